// File: rtl/unidade_busca_instrucao.sv
// unidade_busca_instrucao: instruction fetch unit closing the PC loop with the branch control unit
module unidade_busca_instrucao #(
    parameter int                  LARG_END   = 32,
    parameter int                  LARG_INST  = 32,
    parameter int                  MAX_ESPERA = 15,
    parameter logic [LARG_END-1:0] PC_INICIAL = '0
) (
    input  logic                 clock,
    input  logic                 Reset,
    input  logic                 habilita,
    input  logic                 retoma,
    input  logic [LARG_END-1:0]  ProximoPC,
    output logic [LARG_END-1:0]  ProgramCounter,
    output logic                 mem_req,
    output logic [LARG_END-1:0]  mem_end,
    input  logic                 mem_ack,
    input  logic [LARG_INST-1:0] mem_dado,
    output logic [LARG_INST-1:0] instrucao,
    output logic                 instrucao_valida,
    input  logic                 instrucao_pronta,
    output logic                 parado,
    output logic                 erro_tempo
);
    localparam int LARG_CNT = $clog2(MAX_ESPERA + 1);
    typedef enum logic [2:0] {OCIOSO, BUSCA, ENTREGA, DESVIO, ATUALIZA, PARADO} estado_t;
    estado_t              estado_q, estado_d;
    logic [LARG_END-1:0]  pc_q, pc_d;
    logic [LARG_INST-1:0] instrucao_q, instrucao_d;
    logic [LARG_CNT-1:0]  cnt_q, cnt_d;
    logic                 mem_req_q, mem_req_d;
    logic                 valida_q, valida_d;
    logic                 parado_q, parado_d;
    logic                 erro_q, erro_d;
    logic                 fim_espera;
    logic                 quebra;
    // the last allowed wait cycle without ack ends the fetch; a simultaneous ack takes priority
    assign fim_espera = !mem_ack && (cnt_q == LARG_CNT'(MAX_ESPERA - 1));
    assign quebra     = (ProximoPC == pc_q);
    // state and all output registers
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            estado_q    <= OCIOSO;
            pc_q        <= PC_INICIAL;
            instrucao_q <= '0;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            valida_q    <= 1'b0;
            parado_q    <= 1'b0;
            erro_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            pc_q        <= pc_d;
            instrucao_q <= instrucao_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            valida_q    <= valida_d;
            parado_q    <= parado_d;
            erro_q      <= erro_d;
        end
    end
    // next-state selection
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:   if (habilita) estado_d = BUSCA;
            BUSCA:    estado_d = mem_ack ? ENTREGA : (fim_espera ? PARADO : BUSCA);
            ENTREGA:  if (instrucao_pronta) estado_d = DESVIO;
            DESVIO:   estado_d = ATUALIZA;
            ATUALIZA: estado_d = quebra ? PARADO : BUSCA;
            PARADO:   if (retoma) estado_d = BUSCA;
            default:  estado_d = OCIOSO;
        endcase
    end
    // output flags follow the state being entered so they are registered alongside it
    always_comb begin
        mem_req_d   = (estado_d == BUSCA);
        valida_d    = (estado_d == ENTREGA);
        parado_d    = (estado_d == PARADO);
        erro_d      = (estado_q == BUSCA && estado_d == PARADO) || (erro_q && estado_d != BUSCA);
        cnt_d       = (estado_q == BUSCA && !mem_ack && !fim_espera) ? cnt_q + LARG_CNT'(1) : '0;
        instrucao_d = (estado_q == BUSCA && mem_ack) ? mem_dado : instrucao_q;
        pc_d        = (estado_q == ATUALIZA && !quebra) ? ProximoPC :
                      (estado_q == PARADO && retoma) ? PC_INICIAL : pc_q;
    end
    assign ProgramCounter   = pc_q;
    assign mem_end          = pc_q;
    assign mem_req          = mem_req_q;
    assign instrucao        = instrucao_q;
    assign instrucao_valida = valida_q;
    assign parado           = parado_q;
    assign erro_tempo       = erro_q;
endmodule

// File: tb/tb_unidade_busca_instrucao.sv
// tb_unidade_busca_instrucao: directed self-checking bench for the fetch unit
module tb_unidade_busca_instrucao;
    logic        clock = 1'b0;
    logic        Reset = 1'b1;
    logic        habilita = 1'b0;
    logic        retoma = 1'b0;
    logic [31:0] ProximoPC = '0;
    logic [31:0] ProgramCounter;
    logic        mem_req;
    logic [31:0] mem_end;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_dado = '0;
    logic [31:0] instrucao;
    logic        instrucao_valida;
    logic        instrucao_pronta = 1'b0;
    logic        parado;
    logic        erro_tempo;
    int          n_chk = 0;
    int          n_err = 0;

    unidade_busca_instrucao dut (
        .clock(clock), .Reset(Reset), .habilita(habilita), .retoma(retoma),
        .ProximoPC(ProximoPC), .ProgramCounter(ProgramCounter), .mem_req(mem_req),
        .mem_end(mem_end), .mem_ack(mem_ack), .mem_dado(mem_dado), .instrucao(instrucao),
        .instrucao_valida(instrucao_valida), .instrucao_pronta(instrucao_pronta),
        .parado(parado), .erro_tempo(erro_tempo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // one full fetch: ack now, decoder accepts on first ENTREGA cycle, then offer next PC
    task automatic ciclo(input logic [31:0] dado, input logic [31:0] prox);
        mem_dado = dado;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        instrucao_pronta = 1'b1;
        tick();
        instrucao_pronta = 1'b0;
        ProximoPC = prox;
        tick();
        tick();
    endtask

    initial begin
        logic req_visto;
        #3 Reset = 1'b0;
        tick();
        tick();
        chk("rst_pc", ProgramCounter, 32'h0);
        chk("rst_inst", instrucao, 32'h0);
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_val", {31'b0, instrucao_valida}, 32'h0);
        chk("rst_par", {31'b0, parado}, 32'h0);
        chk("rst_erro", {31'b0, erro_tempo}, 32'h0);
        Reset = 1'b1;
        tick();
        chk("idle_req", {31'b0, mem_req}, 32'h0);
        // first fetch, memory acks on the third request cycle
        habilita = 1'b1;
        tick();
        habilita = 1'b0;
        chk("t1_req_c1", {31'b0, mem_req}, 32'h1);
        chk("t1_end", mem_end, 32'h0);
        tick();
        chk("t1_req_c2", {31'b0, mem_req}, 32'h1);
        tick();
        chk("t1_req_c3", {31'b0, mem_req}, 32'h1);
        mem_dado = 32'h0000_0011;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t1_req_drop", {31'b0, mem_req}, 32'h0);
        chk("t1_inst", instrucao, 32'h11);
        chk("t1_val", {31'b0, instrucao_valida}, 32'h1);
        instrucao_pronta = 1'b1;
        tick();
        instrucao_pronta = 1'b0;
        chk("t1_val_drop", {31'b0, instrucao_valida}, 32'h0);
        ProximoPC = 32'h1;
        tick();
        chk("t1_desvio_pc", ProgramCounter, 32'h0);
        tick();
        chk("t1_pc", ProgramCounter, 32'h1);
        chk("t1_req2", {31'b0, mem_req}, 32'h1);
        chk("t1_end2", mem_end, 32'h1);
        // decoder stalls for five cycles
        mem_dado = 32'h0000_0022;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_dado = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            chk("t2_val_hold", {31'b0, instrucao_valida}, 32'h1);
            chk("t2_inst_hold", instrucao, 32'h22);
            chk("t2_no_req", {31'b0, mem_req}, 32'h0);
            tick();
        end
        // retoma outside PARADO is ignored
        retoma = 1'b1;
        tick();
        retoma = 1'b0;
        chk("t2_retoma_ign", {31'b0, instrucao_valida}, 32'h1);
        chk("t2_retoma_pc", ProgramCounter, 32'h1);
        instrucao_pronta = 1'b1;
        tick();
        instrucao_pronta = 1'b0;
        ProximoPC = 32'h2;
        tick();
        tick();
        chk("t2_pc", ProgramCounter, 32'h2);
        ciclo(32'h33, 32'h3);
        chk("t3_pc3", ProgramCounter, 32'h3);
        // jump
        ciclo(32'h3F, 32'h40);
        chk("t3_jump_pc", ProgramCounter, 32'h40);
        chk("t3_jump_end", mem_end, 32'h40);
        chk("t3_jump_req", {31'b0, mem_req}, 32'h1);
        // break
        ciclo(32'h44, 32'h40);
        chk("t4_parado", {31'b0, parado}, 32'h1);
        chk("t4_pc", ProgramCounter, 32'h40);
        chk("t4_erro", {31'b0, erro_tempo}, 32'h0);
        req_visto = 1'b0;
        habilita = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req_visto = req_visto | mem_req | ~parado;
            tick();
        end
        habilita = 1'b0;
        chk("t4_quiet", {31'b0, req_visto}, 32'h0);
        retoma = 1'b1;
        tick();
        retoma = 1'b0;
        chk("t4_ret_pc", ProgramCounter, 32'h0);
        chk("t4_ret_par", {31'b0, parado}, 32'h0);
        chk("t4_ret_req", {31'b0, mem_req}, 32'h1);
        chk("t4_ret_end", mem_end, 32'h0);
        // timeout: no ack for 15 request cycles
        for (int i = 0; i < 14; i++) begin
            chk("t5_req_wait", {31'b0, mem_req}, 32'h1);
            tick();
        end
        chk("t5_req_last", {31'b0, mem_req}, 32'h1);
        chk("t5_no_err_yet", {31'b0, erro_tempo}, 32'h0);
        tick();
        chk("t5_erro", {31'b0, erro_tempo}, 32'h1);
        chk("t5_parado", {31'b0, parado}, 32'h1);
        chk("t5_req_off", {31'b0, mem_req}, 32'h0);
        retoma = 1'b1;
        tick();
        retoma = 1'b0;
        chk("t5_erro_clr", {31'b0, erro_tempo}, 32'h0);
        chk("t5_par_clr", {31'b0, parado}, 32'h0);
        // ack on exactly the 15th cycle wins
        for (int i = 0; i < 14; i++) tick();
        mem_dado = 32'h55;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t5b_erro", {31'b0, erro_tempo}, 32'h0);
        chk("t5b_par", {31'b0, parado}, 32'h0);
        chk("t5b_val", {31'b0, instrucao_valida}, 32'h1);
        chk("t5b_inst", instrucao, 32'h55);
        instrucao_pronta = 1'b1;
        tick();
        instrucao_pronta = 1'b0;
        ProximoPC = 32'h5;
        tick();
        tick();
        chk("t6_pc", ProgramCounter, 32'h5);
        tick();
        tick();
        chk("t6_req_pre", {31'b0, mem_req}, 32'h1);
        // asynchronous reset in the middle of BUSCA
        #2 Reset = 1'b0;
        #1;
        chk("t6_rst_req", {31'b0, mem_req}, 32'h0);
        chk("t6_rst_pc", ProgramCounter, 32'h0);
        chk("t6_rst_inst", instrucao, 32'h0);
        chk("t6_rst_val", {31'b0, instrucao_valida}, 32'h0);
        tick();
        Reset = 1'b1;
        mem_dado = 32'h99;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("t6_late_req", {31'b0, mem_req}, 32'h0);
        chk("t6_late_val", {31'b0, instrucao_valida}, 32'h0);
        chk("t6_late_inst", instrucao, 32'h0);
        chk("t6_late_pc", ProgramCounter, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
